// File: rtl/plot_framebuffer.sv
// plot_framebuffer: pixel-plot receiver with an internal WIDTH x HEIGHT x 3-bit
// framebuffer, a whole-screen clear sequencer and a paced raster scan-out.
module plot_framebuffer #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int PIX_DIV = 4,
  parameter int H_BLANK = 40,
  parameter int V_BLANK = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       clr_busy,
  output logic       oob_err,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       line_start,
  output logic       frame_start
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int HTOT = WIDTH + H_BLANK;
  localparam int VTOT = HEIGHT + V_BLANK;
  localparam int AW   = $clog2(NPIX);
  localparam int DW   = $clog2(PIX_DIV);
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  localparam logic [AW-1:0] CNT_LAST = AW'(NPIX - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);

  typedef enum logic {IDLE, SWEEP} clr_state_t;

  clr_state_t    state, state_nxt;
  logic [AW-1:0] clr_cnt;

  logic [2:0]    mem [0:NPIX-1];

  logic [14:0]   plot_addr;
  logic          plot_oob;
  logic          we;
  logic [AW-1:0] waddr;
  logic [2:0]    wdata;

  logic [DW-1:0] div;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          tick;
  logic          rd_en;
  logic [14:0]   rd_full;
  logic [AW-1:0] raddr;

  logic          vld_p0;
  logic [2:0]    col_p0;
  logic [7:0]    x_p0;
  logic [6:0]    y_p0;

  // Clear sequencer next-state: a sweep runs to the last address, clear is ignored meanwhile
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = SWEEP;
      SWEEP:   if (clr_cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sequencer state and sweep address counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP && clr_cnt != CNT_LAST) clr_cnt <= clr_cnt + 1'b1;
      else                                       clr_cnt <= '0;
    end
  end

  assign clr_busy = (state == SWEEP);

  // Write port: the sweep owns the port while busy, plots are dropped then
  always_comb begin
    plot_addr = 15'(y) * 15'(WIDTH) + 15'(x);
    plot_oob  = (32'(x) >= WIDTH) || (32'(y) >= HEIGHT);
    we        = 1'b0;
    waddr     = plot_addr[AW-1:0];
    wdata     = colour;
    if (state == SWEEP) begin
      we    = 1'b1;
      waddr = clr_cnt;
      wdata = 3'b000;
    end else if (plot && !plot_oob) begin
      we = 1'b1;
    end
  end

  // Sticky out-of-range flag, only for plots the write path would have taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     oob_err <= 1'b0;
    else if (plot && state == IDLE && plot_oob)    oob_err <= 1'b1;
  end

  // Framebuffer storage, contents survive reset
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Scan timing: pixel divider, horizontal and vertical position counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div  <= '0;
      hpos <= '0;
      vpos <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      if (tick) begin
        hpos <= (hpos == H_LAST) ? '0 : hpos + 1'b1;
        if (hpos == H_LAST) vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
      end
    end
  end

  assign tick    = (div == DIV_LAST);
  assign rd_en   = tick && (32'(hpos) < WIDTH) && (32'(vpos) < HEIGHT);
  assign rd_full = 15'(vpos) * 15'(WIDTH) + 15'(hpos);
  assign raddr   = rd_full[AW-1:0];

  // ---- stage p0: registered read, same-cycle write to the read address is bypassed
  always_ff @(posedge clock) begin
    if (rd_en) begin
      col_p0 <= (we && waddr == raddr) ? wdata : mem[raddr];
      x_p0   <= 8'(hpos);
      y_p0   <= 7'(vpos);
    end
  end

  // Read-issued marker travelling with the p0 data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= rd_en;
  end

  // ---- stage p1: output pixel registers, held between pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_colour  <= '0;
    end else begin
      pix_valid   <= vld_p0;
      line_start  <= vld_p0 && (x_p0 == 8'd0);
      frame_start <= vld_p0 && (x_p0 == 8'd0) && (y_p0 == 7'd0);
      if (vld_p0) begin
        pix_x      <= x_p0;
        pix_y      <= y_p0;
        pix_colour <= col_p0;
      end
    end
  end

endmodule

// File: tb/tb_plot_framebuffer.sv
// Bench for plot_framebuffer: a spec-level model (pixel array, edge counter,
// slot arithmetic) checked every cycle, plus directed literal checks.
module tb_plot_framebuffer;

  localparam int W     = 20;
  localparam int H     = 12;
  localparam int PD    = 4;
  localparam int HB    = 4;
  localparam int VB    = 2;
  localparam int HT    = W + HB;
  localparam int VT    = H + VB;
  localparam int N     = W * H;
  localparam int FRAME = PD * HT * VT;

  logic       clock;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       clear;
  logic       clr_busy;
  logic       oob_err;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       line_start;
  logic       frame_start;

  plot_framebuffer #(
    .WIDTH(W), .HEIGHT(H), .PIX_DIV(PD), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .clear(clear), .clr_busy(clr_busy), .oob_err(oob_err),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .line_start(line_start), .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] m_mem   [0:N-1];
  bit         m_known [0:N-1];
  int  mk;
  int  m_sweep;
  bit  m_oob;
  bit  exp_valid, exp_ls, exp_fs, exp_known;
  int  exp_x, exp_y, exp_col;
  bit  pend_v, pend_known;
  int  pend_x, pend_y, pend_col;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mk = 0; m_sweep = -1; m_oob = 0;
      exp_valid = 0; exp_ls = 0; exp_fs = 0; exp_known = 1;
      exp_x = 0; exp_y = 0; exp_col = 0; pend_v = 0;
    end else begin
      int s, h, v;
      mk++;
      exp_valid = pend_v;
      exp_ls    = pend_v && pend_x == 0;
      exp_fs    = pend_v && pend_x == 0 && pend_y == 0;
      if (pend_v) begin
        exp_x = pend_x; exp_y = pend_y; exp_col = pend_col; exp_known = pend_known;
      end
      pend_v = 0;
      if (m_sweep >= 0) begin
        m_mem[m_sweep] = 3'b000; m_known[m_sweep] = 1;
        m_sweep++;
        if (m_sweep == N) m_sweep = -1;
      end else begin
        if (plot) begin
          if (int'(x) < W && int'(y) < H) begin
            m_mem[int'(y) * W + int'(x)] = colour;
            m_known[int'(y) * W + int'(x)] = 1;
          end else m_oob = 1;
        end
        if (clear) m_sweep = 0;
      end
      if (mk % PD == 0) begin
        s = mk / PD - 1;
        h = s % HT;
        v = (s / HT) % VT;
        if (h < W && v < H) begin
          pend_v = 1; pend_x = h; pend_y = v;
          pend_col = m_mem[v * W + h]; pend_known = m_known[v * W + h];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("pix_valid", pix_valid, exp_valid);
      check("line_start", line_start, exp_ls);
      check("frame_start", frame_start, exp_fs);
      check("pix_x", pix_x, exp_x);
      check("pix_y", pix_y, exp_y);
      check("clr_busy", clr_busy, m_sweep >= 0);
      check("oob_err", oob_err, m_oob);
      if (exp_known) check("pix_colour", pix_colour, exp_col);
    end
  end

  // ---------------- directed helpers ----------------
  int seen [0:N-1];
  int pv_cnt, ls_cnt, fs_cnt, nz_cnt;

  task automatic do_plot(input int px, input int py, input int pc);
    plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(pc);
    @(negedge clock);
    plot = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic record_frame();
    int found;
    found = 0;
    for (int i = 0; i < N; i++) seen[i] = -1;
    pv_cnt = 0; ls_cnt = 0; fs_cnt = 0; nz_cnt = 0;
    @(negedge clock);
    for (int i = 0; i < FRAME + 8 && !frame_start; i++) @(negedge clock);
    found = frame_start;
    check("frame_start_wait", found, 1);
    if (found) begin
      for (int c = 0; c < FRAME; c++) begin
        if (pix_valid) begin
          pv_cnt++;
          if (int'(pix_x) < W && int'(pix_y) < H) seen[int'(pix_y) * W + int'(pix_x)] = int'(pix_colour);
          if (pix_colour != 3'b000) nz_cnt++;
        end
        if (line_start) ls_cnt++;
        if (frame_start) fs_cnt++;
        @(negedge clock);
      end
    end
  endtask

  task automatic first_frame_edge(input string name);
    int first;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clock);
      if (frame_start && first == 0) first = e;
    end
    check(name, first, 5);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt, waited, t, nzlow;
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0; clear = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_oob_err", oob_err, 0);
    check("rst_frame_start", frame_start, 0);
    reset = 1'b0;
    first_frame_edge("first_frame_start_edge");

    // whole-screen clear
    pulse_clear();
    busy_cnt = 0;
    while (clr_busy && busy_cnt < N + 10) begin
      busy_cnt++;
      @(negedge clock);
    end
    check("clr_busy_cycles", busy_cnt, 240);
    record_frame();
    check("clr_frame_valids", pv_cnt, 240);
    check("clr_frame_lines", ls_cnt, 12);
    check("clr_frame_frames", fs_cnt, 1);
    check("clr_frame_nonzero", nz_cnt, 0);

    // three plots
    do_plot(0, 0, 3'b100);
    do_plot(W - 1, H - 1, 3'b010);
    do_plot(7, 5, 3'b001);
    record_frame();
    check("px_0_0", seen[0], 4);
    check("px_last", seen[N - 1], 2);
    check("px_7_5", seen[5 * W + 7], 1);
    check("px_nonzero", nz_cnt, 3);

    // out-of-range plots
    plot = 1'b1; x = 8'(W); y = 7'd0; colour = 3'b111;
    @(negedge clock);
    plot = 1'b0;
    check("oob_set", oob_err, 1);
    do_plot(0, H, 3'b111);
    do_plot(255, 127, 3'b111);
    record_frame();
    check("oob_px_0_0", seen[0], 4);
    check("oob_px_0_1", seen[W], 0);
    check("oob_nonzero", nz_cnt, 3);
    check("oob_sticky", oob_err, 1);

    // plot during a sweep is dropped
    pulse_clear();
    do_plot(3, 3, 3'b110);
    waited = 0;
    while (clr_busy && waited < N + 10) begin
      waited++;
      @(negedge clock);
    end
    check("sweep_done", clr_busy, 0);
    check("sweep_oob_kept", oob_err, 1);
    record_frame();
    check("sweep_px_3_3", seen[3 * W + 3], 0);
    check("sweep_nonzero", nz_cnt, 0);

    // plot on the exact read cycle of (5,0)
    waited = 0;
    t = mk + 1;
    while (!((t % PD == 0) && (((t / PD) - 1) % (HT * VT) == 5)) && waited < FRAME + 8) begin
      @(negedge clock);
      waited++;
      t = mk + 1;
    end
    plot = 1'b1; x = 8'd5; y = 7'd0; colour = 3'b101;
    @(negedge clock);
    plot = 1'b0;
    @(negedge clock);
    check("bypass_valid", pix_valid, 1);
    check("bypass_x", pix_x, 5);
    check("bypass_colour", pix_colour, 5);

    // random plots, mostly in range
    for (int i = 0; i < 400; i++) begin
      plot   = 1'($urandom_range(0, 1));
      x      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(W, 255)) : 8'($urandom_range(0, W - 1));
      y      = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(H, 127)) : 7'($urandom_range(0, H - 1));
      colour = 3'($urandom);
      @(negedge clock);
    end
    plot = 1'b0;
    repeat (FRAME + 8) @(negedge clock);

    // fill every pixel, then abort a sweep with reset at count 100
    for (int a = 0; a < N; a++) do_plot(a % W, a / W, (a % 7) + 1);
    pulse_clear();
    repeat (100) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_pix_valid", pix_valid, 0);
    check("mid_rst_pix_x", pix_x, 0);
    check("mid_rst_pix_y", pix_y, 0);
    check("mid_rst_pix_colour", pix_colour, 0);
    check("mid_rst_clr_busy", clr_busy, 0);
    check("mid_rst_oob_err", oob_err, 0);
    check("mid_rst_line_start", line_start, 0);
    @(negedge clock);
    reset = 1'b0;
    first_frame_edge("mid_rst_frame_start_edge");
    record_frame();
    nzlow = 0;
    for (int a = 0; a < 100; a++) if (seen[a] != 0) nzlow++;
    check("abort_low_zero", nzlow, 0);
    check("abort_px_100", seen[100], 3);
    check("abort_px_last", seen[N - 1], 2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
